// File: rtl/led_blink_sequencer.sv
// Four independent push-button LED blinkers sharing a 1 ms tick; queued requests replay as extra blinks.
// Latency: request to LED lit is one Clock_50 edge; LED, busy and pending are registered.
// Backpressure: none; up to 7 requests queue per channel, further requests are dropped.
module led_blink_sequencer #(
    parameter int TICK_DIV = 50000,
    parameter int ON_MS    = 200,
    parameter int OFF_MS   = 200
) (
    input  logic        Clock_50,
    input  logic        Resetn,
    input  logic [3:0]  PB_pushed,
    output logic [3:0]  LED,
    output logic [3:0]  busy,
    output logic [11:0] pending
);

    localparam int            CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [9:0]    ON_LAST   = 10'(ON_MS - 1);
    localparam logic [9:0]    OFF_LAST  = 10'(OFF_MS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } ch_state_t;

    logic [CW-1:0] tick_cnt;
    logic          tick;

    ch_state_t  state_q [4];
    ch_state_t  state_d [4];
    logic [9:0] timer_q [4];
    logic [9:0] timer_d [4];
    logic [2:0] pend_q  [4];
    logic [2:0] pend_d  [4];
    logic [3:0] led_d;
    logic [3:0] busy_d;

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            state_d[n] = state_q[n];
            timer_d[n] = timer_q[n];
            pend_d[n]  = pend_q[n];
            case (state_q[n])
                S_IDLE: begin
                    if (PB_pushed[n]) begin
                        state_d[n] = S_ON;
                        timer_d[n] = '0;
                    end
                end
                S_ON: begin
                    if (tick) begin
                        if (timer_q[n] == ON_LAST) begin
                            state_d[n] = S_OFF;
                            timer_d[n] = '0;
                        end else begin
                            timer_d[n] = timer_q[n] + 10'd1;
                        end
                    end
                    if (PB_pushed[n] && pend_q[n] != 3'd7) begin
                        pend_d[n] = pend_q[n] + 3'd1;
                    end
                end
                S_OFF: begin
                    if (tick && timer_q[n] == OFF_LAST) begin
                        timer_d[n] = '0;
                        // A request landing on the phase end replaces the dequeue it would have caused
                        if (pend_q[n] != 3'd0) begin
                            state_d[n] = S_ON;
                            if (!PB_pushed[n]) begin
                                pend_d[n] = pend_q[n] - 3'd1;
                            end
                        end else if (PB_pushed[n]) begin
                            state_d[n] = S_ON;
                        end else begin
                            state_d[n] = S_IDLE;
                        end
                    end else begin
                        if (tick) begin
                            timer_d[n] = timer_q[n] + 10'd1;
                        end
                        if (PB_pushed[n] && pend_q[n] != 3'd7) begin
                            pend_d[n] = pend_q[n] + 3'd1;
                        end
                    end
                end
                default: begin
                    state_d[n] = S_IDLE;
                    timer_d[n] = '0;
                    pend_d[n]  = '0;
                end
            endcase
        end
    end

    always_comb begin
        led_d  = '0;
        busy_d = '0;
        for (int n = 0; n < 4; n++) begin
            led_d[n]  = (state_d[n] == S_ON);
            busy_d[n] = (state_d[n] != S_IDLE);
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= S_IDLE;
                timer_q[n] <= '0;
                pend_q[n]  <= '0;
            end
            LED  <= 4'h0;
            busy <= 4'h0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= state_d[n];
                timer_q[n] <= timer_d[n];
                pend_q[n]  <= pend_d[n];
            end
            LED  <= led_d;
            busy <= busy_d;
        end
    end

    assign pending = {pend_q[3], pend_q[2], pend_q[1], pend_q[0]};

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench for led_blink_sequencer with TICK_DIV=4, ON_MS=2, OFF_MS=1.
// Every test restarts from reset so tick edges fall on cycles 4, 8, 12, ... after release.
module tb_led_blink_sequencer;

    logic        Clock_50  = 1'b0;
    logic        Resetn    = 1'b1;
    logic [3:0]  PB_pushed = 4'h0;
    logic [3:0]  LED;
    logic [3:0]  busy;
    logic [11:0] pending;

    int n_chk  = 0;
    int n_pass = 0;

    led_blink_sequencer #(
        .TICK_DIV (4),
        .ON_MS    (2),
        .OFF_MS   (1)
    ) dut (
        .Clock_50  (Clock_50),
        .Resetn    (Resetn),
        .PB_pushed (PB_pushed),
        .LED       (LED),
        .busy      (busy),
        .pending   (pending)
    );

    always #5 Clock_50 = ~Clock_50;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clock_50);
        #1;
    endtask

    // Release reset just after an edge (call it e0) with pb applied for e1.
    task automatic restart(input logic [3:0] pb);
        Resetn    = 1'b0;
        PB_pushed = 4'h0;
        cyc(2);
        Resetn    = 1'b1;
        PB_pushed = pb;
    endtask

    task automatic wait_idle(input int ch, output int rises, output int peak, output int cycles);
        logic prev;
        prev   = 1'b0;
        rises  = 0;
        peak   = 0;
        cycles = 0;
        while (busy[ch] && cycles < 300) begin
            if (LED[ch] && !prev) rises++;
            prev = LED[ch];
            if (int'(pending[3*ch +: 3]) > peak) peak = int'(pending[3*ch +: 3]);
            cyc(1);
            cycles++;
        end
    endtask

    initial begin
        int on_cnt;
        int off_cnt;
        int rises;
        int peak;
        int cycles;
        int first_on;
        int bad;

        // Reset state, asserted asynchronously between clock edges
        #1 Resetn = 1'b0;
        #12;
        check("reset LED", int'(LED), 0);
        check("reset busy", int'(busy), 0);
        check("reset pending", int'(pending), 0);

        // Single pulse ch0: ON spans e1..e7 (ticks at e4, e8), OFF e8..e11, idle at e12
        restart(4'b0001);
        cyc(1);
        PB_pushed = 4'h0;
        on_cnt = 0;
        while (LED[0] && on_cnt < 40) begin
            on_cnt++;
            cyc(1);
        end
        off_cnt = 0;
        while (busy[0] && !LED[0] && off_cnt < 40) begin
            off_cnt++;
            cyc(1);
        end
        check("ch0 on cycles", on_cnt, 7);
        check("ch0 off cycles", off_cnt, 4);
        check("ch0 busy end", int'(busy[0]), 0);
        check("ch0 pending end", int'(pending), 0);

        // Three pulses on ch1 at e1, e3, e5
        restart(4'b0010);
        cyc(1); PB_pushed = 4'h0;
        cyc(1); PB_pushed = 4'b0010;
        cyc(1); PB_pushed = 4'h0;
        cyc(1); PB_pushed = 4'b0010;
        cyc(1); PB_pushed = 4'h0;
        wait_idle(1, rises, peak, cycles);
        check("ch1 finished", int'(cycles < 300), 1);
        check("ch1 blinks", rises, 3);
        check("ch1 pending peak", peak, 2);
        check("ch1 pending end", int'(pending[5:3]), 0);

        // Ten pulses on ch2 (e1..e10): queue saturates at 7, eight blinks total
        restart(4'b0100);
        first_on = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (i == 0) first_on = int'(LED[2]);
        end
        PB_pushed = 4'h0;
        check("ch2 pending saturated", int'(pending[8:6]), 7);
        wait_idle(2, rises, peak, cycles);
        check("ch2 finished", int'(cycles < 300), 1);
        check("ch2 total blinks", first_on + rises, 8);
        check("ch2 pending end", int'(pending[8:6]), 0);

        // ch3: pulses at e1,e2 -> pending 1; pulse on OFF end at e12 keeps it at 1
        restart(4'b1000);
        cyc(1);
        cyc(1); PB_pushed = 4'h0;
        cyc(9);
        check("ch3 in OFF before end", int'({busy[3], LED[3]}), 2);
        check("ch3 pending before end", int'(pending[11:9]), 1);
        PB_pushed = 4'b1000;
        cyc(1); PB_pushed = 4'h0;
        check("ch3 ON after end p1", int'(LED[3]), 1);
        check("ch3 pending after end p1", int'(pending[11:9]), 1);
        cyc(12);
        check("ch3 dequeue at e24", int'({LED[3], pending[11:9]}), 8);
        cyc(11);
        check("ch3 in OFF before e36", int'({busy[3], LED[3]}), 2);
        PB_pushed = 4'b1000;
        cyc(1); PB_pushed = 4'h0;
        check("ch3 ON after end p0", int'(LED[3]), 1);
        check("ch3 pending after end p0", int'(pending[11:9]), 0);
        wait_idle(3, rises, peak, cycles);
        check("ch3 finished", int'(cycles < 300), 1);

        // Short reset mid-ON with pending=3 on ch0
        restart(4'b0001);
        cyc(4);
        PB_pushed = 4'h0;
        check("ch0 pending before reset", int'(pending[2:0]), 3);
        check("ch0 LED before reset", int'(LED[0]), 1);
        #2 Resetn = 1'b0;
        #1;
        check("async reset LED", int'(LED), 0);
        check("async reset busy", int'(busy), 0);
        check("async reset pending", int'(pending), 0);
        #1 Resetn = 1'b1;
        cyc(1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (LED != 4'h0 || busy != 4'h0 || pending != 12'h000) bad++;
            cyc(1);
        end
        check("no activity after reset", bad, 0);

        // All four channels together stay in lockstep
        restart(4'hF);
        cyc(1);
        PB_pushed = 4'h0;
        check("all LED lit", int'(LED), 15);
        check("all busy", int'(busy), 15);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (!(LED == 4'h0 || LED == 4'hF)) bad++;
            if (!(busy == 4'h0 || busy == 4'hF)) bad++;
            if (pending[2:0] != pending[5:3] || pending[2:0] != pending[8:6] ||
                pending[2:0] != pending[11:9]) bad++;
            cyc(1);
        end
        check("channels lockstep", bad, 0);
        check("all idle at end", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
